// File: rtl/mmio_pkg.sv
// Purpose : shared constants and types for the MMIO I/O controller.
// Contents: MMIO word indices, status-word bit positions, receive FSM state enum.
// Used by : mmio_io_controller (imports mmio_pkg::*).
package mmio_pkg;

    // Word indices of the MMIO block at the top of data memory
    localparam int MMIO_INPUT_DATA   = 512;
    localparam int MMIO_INPUT_READY  = 513;
    localparam int MMIO_OUTPUT_DATA  = 514;
    localparam int MMIO_OUTPUT_READY = 515;

    // Bit positions inside the input_ready status word
    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_TX_OVF   = 2;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_e;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Purpose : synchronous FIFO holding posted output words until the host drains them.
// Latency : a push is visible at the head one edge later; pop advances the head at the edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
// Ports   : i_clk/i_rst_n, i_push/i_push_dat, i_pop, o_head_dat, o_full, o_empty, o_count.
module mmio_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_push_dat,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_head_dat,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH+1)-1:0]    o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CW'(DEPTH));
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage needs no reset: contents are don't-care while empty
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_io_controller.sv
// Purpose : sequences MMIO words 512..515 between a host rx/tx stream and data_memory.
// Latency : rx word visible one edge after transfer; posted word at tx head one edge after post.
// Backpressure: rx_ready low while a word awaits CPU ack; tx posts dropped (sticky overflow) when FIFO full.
// Ports   : clk/rst_n; snooped addr/data_in/wr_en; output_data in; input_data/input_ready out;
//           rx_data/rx_valid/rx_ready receive stream; tx_data/tx_valid/tx_ready transmit stream.
module mmio_io_controller
    import mmio_pkg::*;
#(
    parameter int TX_DEPTH   = 4,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH+1:0]   addr,
    input  logic [BUS_WIDTH-1:0]    data_in,
    input  logic                    wr_en,
    input  logic [BUS_WIDTH-1:0]    output_data,
    output logic [BUS_WIDTH-1:0]    input_data,
    output logic [BUS_WIDTH-1:0]    input_ready,
    input  logic [BUS_WIDTH-1:0]    rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [BUS_WIDTH-1:0]    tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);

    localparam int CW = $clog2(TX_DEPTH+1);

    rx_state_e              r_state;
    rx_state_e              w_state_nxt;
    logic [BUS_WIDTH-1:0]   r_input_data;
    logic                   r_tx_ovf;

    logic [ADDR_WIDTH-1:0]  w_word_idx;
    logic                   w_ack;
    logic                   w_post;
    logic                   w_rx_ready;
    logic                   w_rx_avail;
    logic                   w_rx_load;
    logic                   w_pop;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [CW-1:0]          w_fifo_count;
    logic                   w_tx_full;
    logic                   w_unused;

    // Snoop decode: byte address to word index; ack data value is irrelevant
    assign w_word_idx = addr[ADDR_WIDTH+1:2];
    assign w_ack      = wr_en & (w_word_idx == ADDR_WIDTH'(MMIO_INPUT_READY));
    assign w_post     = wr_en & (w_word_idx == ADDR_WIDTH'(MMIO_OUTPUT_READY)) & data_in[0];
    assign w_unused   = ^{addr[1:0], data_in[BUS_WIDTH-1:1]};

    // Receive FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Receive FSM: next state. Ack and load cannot coincide since rx_ready is low in RX_FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_EMPTY: if (rx_valid) w_state_nxt = RX_FULL;
            RX_FULL:  if (w_ack)    w_state_nxt = RX_EMPTY;
            default:  w_state_nxt = RX_EMPTY;
        endcase
    end

    // Receive FSM: outputs decoded from the state register only
    always_comb begin
        w_rx_ready = 1'b0;
        w_rx_avail = 1'b0;
        case (r_state)
            RX_EMPTY: w_rx_ready = 1'b1;
            RX_FULL:  w_rx_avail = 1'b1;
            default:  w_rx_ready = 1'b0;
        endcase
    end

    assign w_rx_load = w_rx_ready & rx_valid;

    // input_data holds its last value across an ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_input_data <= '0;
        end else if (w_rx_load) begin
            r_input_data <= rx_data;
        end
    end

    // Transmit path
    assign w_pop = tx_valid & tx_ready;

    mmio_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (BUS_WIDTH)
    ) u_tx_fifo (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_push     (w_post),
        .i_push_dat (output_data),
        .i_pop      (w_pop),
        .o_head_dat (tx_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    // Overflow is sticky: only a post that finds the FIFO full with no same-cycle pop is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ovf <= 1'b0;
        end else if (w_post & w_fifo_full & ~w_pop) begin
            r_tx_ovf <= 1'b1;
        end
    end

    assign w_tx_full = (w_fifo_count == CW'(TX_DEPTH));

    // Status word assembly
    always_comb begin
        input_ready                = '0;
        input_ready[STAT_RX_AVAIL] = w_rx_avail;
        input_ready[STAT_TX_FULL]  = w_tx_full;
        input_ready[STAT_TX_OVF]   = r_tx_ovf;
    end

    assign input_data = r_input_data;
    assign rx_ready   = w_rx_ready;
    assign tx_valid   = ~w_fifo_empty;

endmodule

// File: tb/tb_mmio_io_controller.sv
module tb_mmio_io_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] addr;
    logic [31:0] data_in;
    logic        wr_en;
    logic [31:0] output_data;
    logic [31:0] input_data;
    logic [31:0] input_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_io_controller #(
        .TX_DEPTH   (4),
        .BUS_WIDTH  (32),
        .ADDR_WIDTH (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .output_data (output_data),
        .input_data  (input_data),
        .input_ready (input_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle CPU store on the snooped bus
    task automatic store(input logic [11:0] a, input logic [31:0] d);
        addr    = a;
        data_in = d;
        wr_en   = 1'b1;
        cyc();
        wr_en   = 1'b0;
        addr    = '0;
        data_in = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic post(input logic [31:0] v);
        output_data = v;
        store(12'h80C, 32'h1);
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; data_in = '0; wr_en = 1'b0;
        output_data = '0; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0;
        #2;
        chk("rst_input_data",  input_data,  32'h0);
        chk("rst_input_ready", input_ready, 32'h0);
        chk("rst_rx_ready",    {31'b0, rx_ready}, 32'h1);
        chk("rst_tx_valid",    {31'b0, tx_valid}, 32'h0);
        #10;
        rst_n = 1'b1;
        cyc();

        // Receive, stall, ack
        rx_data = 32'hDEADBEEF; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        chk("rx1_data",   input_data,  32'hDEADBEEF);
        chk("rx1_status", input_ready, 32'h1);
        chk("rx1_ready",  {31'b0, rx_ready}, 32'h0);
        rx_data = 32'hCAFEF00D; rx_valid = 1'b1;
        cyc();
        chk("stall_data",  input_data, 32'hDEADBEEF);
        chk("stall_ready", {31'b0, rx_ready}, 32'h0);
        store(12'h804, 32'h0);
        chk("ack_status", input_ready, 32'h0);
        chk("ack_ready",  {31'b0, rx_ready}, 32'h1);
        chk("ack_keep",   input_data, 32'hDEADBEEF);
        cyc();
        rx_valid = 1'b0;
        chk("rx2_data",   input_data,  32'hCAFEF00D);
        chk("rx2_status", input_ready, 32'h1);
        store(12'h804, 32'hFFFFFFFF);
        chk("ack2_status", input_ready, 32'h0);

        // Stores that must not change anything
        store(12'h804, 32'h1);
        chk("ack_empty_status", input_ready, 32'h0);
        chk("ack_empty_ready",  {31'b0, rx_ready}, 32'h1);
        store(12'h800, 32'h12345678);
        chk("w512_data",   input_data,  32'hCAFEF00D);
        chk("w512_status", input_ready, 32'h0);
        output_data = 32'h55;
        store(12'h80C, 32'hFFFFFFFE);
        chk("post_bit0_zero", {31'b0, tx_valid}, 32'h0);
        store(12'h808, 32'h1);
        chk("w514_no_post", {31'b0, tx_valid}, 32'h0);

        // Two posts then drain
        post(32'h11);
        post(32'h22);
        chk("tx2_valid", {31'b0, tx_valid}, 32'h1);
        chk("tx2_head",  tx_data, 32'h11);
        chk("tx2_status", input_ready, 32'h0);
        tx_ready = 1'b1;
        cyc();
        chk("drain_head2",  tx_data, 32'h22);
        chk("drain_valid2", {31'b0, tx_valid}, 32'h1);
        cyc();
        chk("drain_empty", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // Overflow: five posts into a depth-4 FIFO
        for (int i = 0; i < 4; i++) post(32'hA0 + i);
        chk("fill_status", input_ready, 32'h2);
        post(32'hA4);
        chk("ovf_status", input_ready, 32'h6);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_drain%0d", i), tx_data, 32'hA0 + i);
            cyc();
        end
        tx_ready = 1'b0;
        chk("ovf_drained_valid", {31'b0, tx_valid}, 32'h0);
        chk("ovf_sticky", input_ready, 32'h4);

        // Full FIFO, post and pop in the same cycle
        do_reset();
        chk("rst2_status", input_ready, 32'h0);
        for (int i = 0; i < 4; i++) post(32'hB0 + i);
        chk("full_status", input_ready, 32'h2);
        tx_ready = 1'b1;
        post(32'hB4);
        tx_ready = 1'b0;
        chk("pushpop_status", input_ready, 32'h2);
        chk("pushpop_head",   tx_data, 32'hB1);
        tx_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("pushpop_drain%0d", i), tx_data, 32'hB0 + i);
            cyc();
        end
        tx_ready = 1'b0;
        chk("pushpop_empty", {31'b0, tx_valid}, 32'h0);

        // Asynchronous reset mid-operation
        post(32'h77);
        post(32'h88);
        rx_data = 32'h13579BDF; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
        chk("pre_rst_status", input_ready, 32'h1);
        chk("pre_rst_valid",  {31'b0, tx_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_valid",    {31'b0, tx_valid}, 32'h0);
        chk("arst_input_ready", input_ready, 32'h0);
        chk("arst_input_data",  input_data,  32'h0);
        chk("arst_rx_ready",    {31'b0, rx_ready}, 32'h1);
        #4;
        rst_n = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
